// File: rtl/ahb2apb_ctrl_if.sv
// AHB-slave / APB-master signal bundle for ahb2apb_ctrl.
// The slave modport is the bridge's view; the master modport is the upstream/downstream view.
interface ahb2apb_ctrl_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NSLV   = 3;

    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic              HREADYin;
    logic [ADDR_W-1:0] HADDR;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADYout;
    logic [1:0]        HRESP;
    logic [DATA_W-1:0] HRDATA;
    logic [DATA_W-1:0] PRDATA;
    logic [NSLV-1:0]   PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;

    modport slave (
        input  HTRANS, HWRITE, HREADYin, HADDR, HSIZE, HWDATA, PRDATA,
        output HREADYout, HRESP, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport master (
        output HTRANS, HWRITE, HREADYin, HADDR, HSIZE, HWDATA, PRDATA,
        input  HREADYout, HRESP, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/ahb2apb_ctrl.sv
// AHB single-transfer to APB bridge: decodes three APB regions and runs SETUP/ENABLE,
// stretching the AHB data phase with HREADYout. All APB-side outputs are registered.
module ahb2apb_ctrl (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb2apb_ctrl_if.slave        bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NSLV   = 3;

    localparam logic [ADDR_W-1:0] BASE0       = 32'h8000_0000;
    localparam logic [ADDR_W-1:0] BASE1       = 32'h8400_0000;
    localparam logic [ADDR_W-1:0] BASE2       = 32'h8800_0000;
    localparam logic [ADDR_W-1:0] REGION_MASK = 32'hFC00_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        RENABLE = 3'd2,
        WWAIT   = 3'd3,
        WRITE   = 3'd4,
        WENABLE = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_r, addr_d;
    logic              write_r, write_d;
    logic [NSLV-1:0]   sel_r, sel_d;

    logic              hready_q, hready_d;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    logic [NSLV-1:0]   sel_dec;
    logic              valid;
    logic              unused_hsize;

    assign unused_hsize = ^bus.HSIZE;

    // Region decode, BASE0 has highest priority.
    always_comb begin
        sel_dec = NSLV'(0);
        if ((bus.HADDR & REGION_MASK) == BASE0)
            sel_dec = NSLV'(3'b001);
        else if ((bus.HADDR & REGION_MASK) == BASE1)
            sel_dec = NSLV'(3'b010);
        else if ((bus.HADDR & REGION_MASK) == BASE2)
            sel_dec = NSLV'(3'b100);
    end

    assign valid = bus.HREADYin && (bus.HTRANS inside {2'b00, 2'b01}) && hready_q
                   && (sel_dec != NSLV'(0));

    // Next state, transfer capture, and output values for the state being entered.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_r;
        write_d   = write_r;
        sel_d     = sel_r;
        hready_d  = 1'b1;
        psel_d    = psel_q;
        penable_d = 1'b0;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;

        case (state_q)
            IDLE, RENABLE, WENABLE: begin
                if (valid) begin
                    addr_d  = bus.HADDR;
                    write_d = bus.HWRITE;
                    sel_d   = sel_dec;
                    state_d = bus.HWRITE ? WWAIT : READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ:    state_d = RENABLE;
            WWAIT: begin
                pwdata_d = bus.HWDATA;
                state_d  = WRITE;
            end
            WRITE:   state_d = WENABLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            IDLE: begin
                psel_d   = NSLV'(0);
                pwrite_d = 1'b0;
            end
            READ: begin
                psel_d   = sel_d;
                paddr_d  = addr_d;
                pwrite_d = 1'b0;
                hready_d = 1'b0;
            end
            RENABLE: penable_d = 1'b1;
            WWAIT: begin
                psel_d   = NSLV'(0);
                pwrite_d = 1'b0;
                hready_d = 1'b0;
            end
            WRITE: begin
                psel_d   = sel_r;
                paddr_d  = addr_r;
                pwrite_d = write_r;
                hready_d = 1'b0;
            end
            WENABLE: penable_d = 1'b1;
            default: begin
                psel_d   = NSLV'(0);
                pwrite_d = 1'b0;
            end
        endcase
    end

    // State and output registers; HRESETn is an active-high synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            state_q   <= IDLE;
            addr_r    <= '0;
            write_r   <= 1'b0;
            sel_r     <= '0;
            hready_q  <= 1'b1;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_r    <= addr_d;
            write_r   <= write_d;
            sel_r     <= sel_d;
            hready_q  <= hready_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign bus.HREADYout = hready_q;
    assign bus.HRESP     = 2'b00;
    assign bus.HRDATA    = bus.PRDATA;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
endmodule

// File: tb/tb_ahb2apb_ctrl.sv
// Directed bench for ahb2apb_ctrl: reset, write, read, decode miss, back-to-back,
// transfer qualifiers and reset during an APB write.
module tb_ahb2apb_ctrl;
    logic HCLK;
    logic HRESETn;
    int   n_chk;
    int   n_err;

    ahb2apb_ctrl_if bus ();

    ahb2apb_ctrl dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        bus.HTRANS   = 2'b10;
        bus.HWRITE   = 1'b0;
        bus.HREADYin = 1'b1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b1;
        bus_idle();
        tick();
        tick();
        HRESETn = 1'b0;
        n_chk++; if (bus.HREADYout !== 1'b1) begin n_err++; $display("FAIL rst_hready: got %b want 1", bus.HREADYout); end
        n_chk++; if (bus.PSEL !== 3'b000) begin n_err++; $display("FAIL rst_psel: got %b want 000", bus.PSEL); end
        n_chk++; if (bus.PENABLE !== 1'b0) begin n_err++; $display("FAIL rst_penable: got %b want 0", bus.PENABLE); end
        n_chk++; if (bus.PWRITE !== 1'b0) begin n_err++; $display("FAIL rst_pwrite: got %b want 0", bus.PWRITE); end
        n_chk++; if (bus.PADDR !== 32'h0) begin n_err++; $display("FAIL rst_paddr: got %h want 0", bus.PADDR); end
        n_chk++; if (bus.PWDATA !== 32'h0) begin n_err++; $display("FAIL rst_pwdata: got %h want 0", bus.PWDATA); end
        n_chk++; if (bus.HRESP !== 2'b00) begin n_err++; $display("FAIL rst_hresp: got %b want 00", bus.HRESP); end
    endtask

    task automatic test_write();
        int pen_cnt;
        int lo_cnt;
        pen_cnt = 0;
        lo_cnt  = 0;
        bus.HTRANS = 2'b00; bus.HWRITE = 1'b1; bus.HADDR = 32'h8400_0000;
        tick();
        bus_idle();
        bus.HWDATA = 32'h0000_0055;
        if (bus.PENABLE === 1'b1) pen_cnt++;
        if (bus.HREADYout === 1'b0) lo_cnt++;
        n_chk++; if (bus.PSEL !== 3'b000) begin n_err++; $display("FAIL wr_wwait_psel: got %b want 000", bus.PSEL); end
        tick();
        bus.HWDATA = 32'hFFFF_FFFF;
        if (bus.PENABLE === 1'b1) pen_cnt++;
        if (bus.HREADYout === 1'b0) lo_cnt++;
        n_chk++; if (bus.PSEL !== 3'b010) begin n_err++; $display("FAIL wr_psel: got %b want 010", bus.PSEL); end
        n_chk++; if (bus.PWRITE !== 1'b1) begin n_err++; $display("FAIL wr_pwrite: got %b want 1", bus.PWRITE); end
        n_chk++; if (bus.PADDR !== 32'h8400_0000) begin n_err++; $display("FAIL wr_paddr: got %h want 84000000", bus.PADDR); end
        n_chk++; if (bus.PWDATA !== 32'h0000_0055) begin n_err++; $display("FAIL wr_pwdata: got %h want 00000055", bus.PWDATA); end
        tick();
        if (bus.PENABLE === 1'b1) pen_cnt++;
        if (bus.HREADYout === 1'b0) lo_cnt++;
        n_chk++; if (bus.PENABLE !== 1'b1 || bus.HREADYout !== 1'b1) begin n_err++; $display("FAIL wr_enable: got pen=%b rdy=%b want 1 1", bus.PENABLE, bus.HREADYout); end
        n_chk++; if (bus.PWDATA !== 32'h0000_0055) begin n_err++; $display("FAIL wr_pwdata_hold: got %h want 00000055", bus.PWDATA); end
        tick();
        if (bus.PENABLE === 1'b1) pen_cnt++;
        if (bus.HREADYout === 1'b0) lo_cnt++;
        n_chk++; if (bus.PSEL !== 3'b000) begin n_err++; $display("FAIL wr_idle_psel: got %b want 000", bus.PSEL); end
        n_chk++; if (pen_cnt != 1) begin n_err++; $display("FAIL wr_penable_cycles: got %0d want 1", pen_cnt); end
        n_chk++; if (lo_cnt != 2) begin n_err++; $display("FAIL wr_wait_cycles: got %0d want 2", lo_cnt); end
    endtask

    task automatic test_read();
        bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HADDR = 32'h8400_0000;
        bus.PRDATA = 32'h0000_02A7;
        tick();
        bus_idle();
        n_chk++; if (bus.PSEL !== 3'b010) begin n_err++; $display("FAIL rd_psel: got %b want 010", bus.PSEL); end
        n_chk++; if (bus.PWRITE !== 1'b0) begin n_err++; $display("FAIL rd_pwrite: got %b want 0", bus.PWRITE); end
        n_chk++; if (bus.HREADYout !== 1'b0 || bus.PENABLE !== 1'b0) begin n_err++; $display("FAIL rd_setup: got rdy=%b pen=%b want 0 0", bus.HREADYout, bus.PENABLE); end
        tick();
        n_chk++; if (bus.HREADYout !== 1'b1 || bus.PENABLE !== 1'b1) begin n_err++; $display("FAIL rd_enable: got rdy=%b pen=%b want 1 1", bus.HREADYout, bus.PENABLE); end
        n_chk++; if (bus.HRDATA !== 32'h0000_02A7) begin n_err++; $display("FAIL rd_hrdata: got %h want 000002a7", bus.HRDATA); end
        tick();
        n_chk++; if (bus.PSEL !== 3'b000 || bus.HREADYout !== 1'b1) begin n_err++; $display("FAIL rd_idle: got psel=%b rdy=%b want 000 1", bus.PSEL, bus.HREADYout); end
    endtask

    task automatic test_decode_ignore();
        bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HADDR = 32'h0000_0000;
        tick();
        n_chk++; if (bus.PSEL !== 3'b000 || bus.HREADYout !== 1'b1) begin n_err++; $display("FAIL dec_miss: got psel=%b rdy=%b want 000 1", bus.PSEL, bus.HREADYout); end
        n_chk++; if (bus.HRESP !== 2'b00) begin n_err++; $display("FAIL dec_miss_hresp: got %b want 00", bus.HRESP); end
        bus.HADDR = 32'h8800_0010;
        tick();
        bus_idle();
        n_chk++; if (bus.PSEL !== 3'b100) begin n_err++; $display("FAIL dec_psel2: got %b want 100", bus.PSEL); end
        n_chk++; if (bus.PADDR !== 32'h8800_0010) begin n_err++; $display("FAIL dec_paddr2: got %h want 88000010", bus.PADDR); end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HADDR = 32'h8000_0004;
        tick();
        // Next address phase is presented while the bridge is still stretching.
        bus.HWRITE = 1'b1; bus.HADDR = 32'h8000_0008;
        n_chk++; if (bus.PSEL !== 3'b001 || bus.PADDR !== 32'h8000_0004) begin n_err++; $display("FAIL b2b_rd_setup: got psel=%b paddr=%h want 001 80000004", bus.PSEL, bus.PADDR); end
        tick();
        n_chk++; if (bus.PSEL !== 3'b001 || bus.PENABLE !== 1'b1 || bus.PWRITE !== 1'b0) begin n_err++; $display("FAIL b2b_renable: got psel=%b pen=%b pw=%b want 001 1 0", bus.PSEL, bus.PENABLE, bus.PWRITE); end
        tick();
        bus_idle();
        bus.HWDATA = 32'hDEAD_BEEF;
        n_chk++; if (bus.HREADYout !== 1'b0 || bus.PENABLE !== 1'b0) begin n_err++; $display("FAIL b2b_wwait: got rdy=%b pen=%b want 0 0", bus.HREADYout, bus.PENABLE); end
        tick();
        bus.HWDATA = 32'h0;
        n_chk++; if (bus.PSEL !== 3'b001 || bus.PWRITE !== 1'b1 || bus.PADDR !== 32'h8000_0008) begin n_err++; $display("FAIL b2b_write: got psel=%b pw=%b paddr=%h want 001 1 80000008", bus.PSEL, bus.PWRITE, bus.PADDR); end
        n_chk++; if (bus.PWDATA !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL b2b_pwdata: got %h want deadbeef", bus.PWDATA); end
        tick();
        n_chk++; if (bus.PSEL !== 3'b001 || bus.PENABLE !== 1'b1 || bus.HREADYout !== 1'b1) begin n_err++; $display("FAIL b2b_wenable: got psel=%b pen=%b rdy=%b want 001 1 1", bus.PSEL, bus.PENABLE, bus.HREADYout); end
        tick();
    endtask

    task automatic test_qualifiers();
        logic [1:0] htr [3];
        logic       hri [3];
        htr[0] = 2'b00; hri[0] = 1'b0;
        htr[1] = 2'b10; hri[1] = 1'b1;
        htr[2] = 2'b11; hri[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.HTRANS = htr[i]; bus.HREADYin = hri[i];
            bus.HWRITE = 1'b0; bus.HADDR = 32'h8000_0000;
            tick();
            n_chk++; if (bus.PSEL !== 3'b000 || bus.HREADYout !== 1'b1) begin n_err++; $display("FAIL qual_%0d: got psel=%b rdy=%b want 000 1", i, bus.PSEL, bus.HREADYout); end
        end
        bus_idle();
        tick();
    endtask

    task automatic test_reset_mid_write();
        int pen_cnt;
        pen_cnt = 0;
        bus.HTRANS = 2'b00; bus.HWRITE = 1'b1; bus.HADDR = 32'h8800_0000;
        tick();
        bus_idle();
        bus.HWDATA = 32'h0000_1234;
        tick();
        n_chk++; if (bus.PSEL !== 3'b100 || bus.PWDATA !== 32'h0000_1234) begin n_err++; $display("FAIL rmw_write: got psel=%b pwdata=%h want 100 00001234", bus.PSEL, bus.PWDATA); end
        HRESETn = 1'b1;
        tick();
        HRESETn = 1'b0;
        if (bus.PENABLE === 1'b1) pen_cnt++;
        n_chk++; if (bus.PSEL !== 3'b000 || bus.HREADYout !== 1'b1) begin n_err++; $display("FAIL rmw_reset: got psel=%b rdy=%b want 000 1", bus.PSEL, bus.HREADYout); end
        n_chk++; if (bus.PWDATA !== 32'h0 || bus.PADDR !== 32'h0) begin n_err++; $display("FAIL rmw_data: got pwdata=%h paddr=%h want 0 0", bus.PWDATA, bus.PADDR); end
        tick();
        if (bus.PENABLE === 1'b1) pen_cnt++;
        tick();
        if (bus.PENABLE === 1'b1) pen_cnt++;
        n_chk++; if (pen_cnt != 0) begin n_err++; $display("FAIL rmw_no_enable: got %0d want 0", pen_cnt); end
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        HRESETn      = 1'b1;
        bus.HTRANS   = 2'b10;
        bus.HWRITE   = 1'b0;
        bus.HREADYin = 1'b1;
        bus.HADDR    = 32'h0;
        bus.HSIZE    = 3'b010;
        bus.HWDATA   = 32'h0;
        bus.PRDATA   = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_decode_ignore();
        test_back_to_back();
        test_qualifiers();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
